// File: rtl/usr_deser8.sv
// Serial-in, parallel-out receiver for the USR serial link: rebuilds words in
// either bit order and presents them through a one-word valid/ready holding register.
module usr_deser8 #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sdata,
    input  logic                       sen,
    input  logic                       lsb_first,
    input  logic                       flush,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overrun,
    input  logic                       ovr_clr,
    output logic [$clog2(WIDTH):0]     bit_cnt
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {EMPTY, FULL} hold_state_t;

    hold_state_t        state_reg, state_next;
    logic [WIDTH-1:0]   sh_reg, sh_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic               ord_reg, ord_next;
    logic [WIDTH-1:0]   data_reg, data_next;
    logic               ovr_reg, ovr_next;

    logic               accept;
    logic               ord_eff;
    logic               complete;
    logic               pop;
    logic               load_word;
    logic               drop;
    logic [WIDTH-1:0]   msb_shift;
    logic [WIDTH-1:0]   lsb_shift;
    logic [WIDTH-1:0]   sh_shifted;

    // Both shift directions are built up front; the word's latched order picks one.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_msb_in
                assign msb_shift[gi] = sdata;
            end else begin : g_msb_mv
                assign msb_shift[gi] = sh_reg[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_lsb_in
                assign lsb_shift[gi] = sdata;
            end else begin : g_lsb_mv
                assign lsb_shift[gi] = sh_reg[gi+1];
            end
        end
    endgenerate

    assign accept     = sen && !flush;
    // The first bit of a word takes the live lsb_first; later bits use the latch.
    assign ord_eff    = (cnt_reg == '0) ? lsb_first : ord_reg;
    assign sh_shifted = ord_eff ? lsb_shift : msb_shift;
    assign complete   = accept && (cnt_reg == CW'(WIDTH - 1));
    assign pop        = (state_reg == FULL) && out_ready;

    // Assembly side
    always_comb begin
        sh_next  = sh_reg;
        cnt_next = cnt_reg;
        ord_next = ord_reg;
        if (flush) begin
            sh_next  = '0;
            cnt_next = '0;
        end else if (sen) begin
            sh_next  = sh_shifted;
            ord_next = ord_eff;
            cnt_next = complete ? '0 : cnt_reg + CW'(1);
        end
    end

    // Holding register FSM
    always_comb begin
        state_next = state_reg;
        load_word  = 1'b0;
        drop       = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (complete) begin
                    state_next = FULL;
                    load_word  = 1'b1;
                end
            end
            FULL: begin
                if (complete && pop) begin
                    load_word = 1'b1;
                end else if (pop) begin
                    state_next = EMPTY;
                end else if (complete) begin
                    drop = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        data_next = load_word ? sh_shifted : data_reg;
        ovr_next  = ovr_reg;
        // A drop in the same cycle as a clear leaves the flag set.
        if (drop) begin
            ovr_next = 1'b1;
        end else if (ovr_clr) begin
            ovr_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            sh_reg    <= '0;
            cnt_reg   <= '0;
            ord_reg   <= 1'b0;
            data_reg  <= '0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sh_reg    <= sh_next;
            cnt_reg   <= cnt_next;
            ord_reg   <= ord_next;
            data_reg  <= data_next;
            ovr_reg   <= ovr_next;
        end
    end

    assign out_data  = data_reg;
    assign out_valid = (state_reg == FULL);
    assign overrun   = ovr_reg;
    assign bit_cnt   = cnt_reg;

endmodule

// File: tb/tb_usr_deser8.sv
// Directed bench for usr_deser8: bit order, overrun, pop/complete overlap,
// flush and asynchronous reset, checked with immediate assertions.
module tb_usr_deser8;

    logic       clk;
    logic       rst_n;
    logic       sdata;
    logic       sen;
    logic       lsb_first;
    logic       flush;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overrun;
    logic       ovr_clr;
    logic [3:0] bit_cnt;

    int errors = 0;
    int checks = 0;

    usr_deser8 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sdata     (sdata),
        .sen       (sen),
        .lsb_first (lsb_first),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr),
        .bit_cnt   (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic send_bit(input logic b);
        sdata = b;
        sen   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sen   = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic lsb);
        lsb_first = lsb;
        for (int i = 0; i < 8; i++) begin
            send_bit(lsb ? w[i] : w[7-i]);
        end
    endtask

    task automatic idle(input logic rdy);
        out_ready = rdy;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [7:0] w;

    initial begin
        rst_n = 1'b0; sdata = 1'b0; sen = 1'b0; lsb_first = 1'b0;
        flush = 1'b0; out_ready = 1'b0; ovr_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_data",  out_data,  8'h00);
        check("rst_valid", out_valid, 1'b0);
        check("rst_ovr",   overrun,   1'b0);
        check("rst_cnt",   bit_cnt,   4'd0);
        rst_n = 1'b1;

        // MSB-first 1,0,1,0,0,1,0,1
        lsb_first = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("msb_cnt3", bit_cnt, 4'd3);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        check("msb_valid7", out_valid, 1'b0);
        send_bit(1'b1);
        check("msb_data",  out_data,  8'hA5);
        check("msb_valid", out_valid, 1'b1);
        check("msb_cnt0",  bit_cnt,   4'd0);
        idle(1'b1);
        check("pop_empty", out_valid, 1'b0);

        // LSB-first 1,0,0,0,1,1,1,0 with lsb_first dropped after the first bit
        lsb_first = 1'b1;
        send_bit(1'b1);
        lsb_first = 1'b0;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        check("lsb_data",  out_data,  8'h71);
        check("lsb_valid", out_valid, 1'b1);
        idle(1'b1);

        // Overrun: second word dropped while full
        send_word(8'h3C, 1'b0);
        check("ovr_first", out_data, 8'h3C);
        check("ovr_pre",   overrun,  1'b0);
        send_word(8'hC3, 1'b0);
        check("ovr_keep",  out_data,  8'h3C);
        check("ovr_valid", out_valid, 1'b1);
        check("ovr_set",   overrun,   1'b1);
        ovr_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ovr_clr = 1'b0;
        check("ovr_clr", overrun, 1'b0);
        idle(1'b1);

        // Pop and completion on the same edge
        send_word(8'h12, 1'b0);
        check("sim_first", out_data, 8'h12);
        w = 8'h34;
        for (int i = 0; i < 7; i++) send_bit(w[7-i]);
        check("sim_hold", out_data, 8'h12);
        out_ready = 1'b1;
        send_bit(w[0]);
        check("sim_data",  out_data,  8'h34);
        check("sim_valid", out_valid, 1'b1);
        check("sim_ovr",   overrun,   1'b0);
        idle(1'b1);
        check("sim_empty", out_valid, 1'b0);

        // Flush mid-word discards the partial word and the coincident bit
        lsb_first = 1'b0;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        check("fl_cnt3", bit_cnt, 4'd3);
        flush = 1'b1;
        send_bit(1'b0);
        flush = 1'b0;
        check("fl_cnt0",  bit_cnt,   4'd0);
        check("fl_valid", out_valid, 1'b0);
        send_word(8'hFF, 1'b0);
        check("fl_data", out_data, 8'hFF);
        idle(1'b1);

        // Asynchronous reset mid-word while full and overrun
        send_word(8'h55, 1'b0);
        send_word(8'hAA, 1'b0);
        check("rs_full", out_data, 8'h55);
        check("rs_ovr1", overrun,  1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("rs_cnt5", bit_cnt, 4'd5);
        #2 rst_n = 1'b0;
        #1;
        check("rs_data",  out_data,  8'h00);
        check("rs_valid", out_valid, 1'b0);
        check("rs_ovr",   overrun,   1'b0);
        check("rs_cnt",   bit_cnt,   4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_word(8'h81, 1'b0);
        check("rs_new",   out_data,  8'h81);
        check("rs_nval",  out_valid, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
